// File: rtl/bcd_counter_ndigit_pkg.sv
// -----------------------------------------------------------------------------
// bcd_counter_ndigit_pkg
// Shared BCD constants, per-digit operation codes and digit arithmetic helpers
// used by the N-digit BCD counter, its digit cells and its invariant checker.
// -----------------------------------------------------------------------------
package bcd_counter_ndigit_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Operation applied to one digit register on the next clock edge
    typedef enum logic [1:0] {
        CELL_HOLD = 2'd0,
        CELL_LOAD = 2'd1,
        CELL_INC  = 2'd2,
        CELL_DEC  = 2'd3
    } cell_op_e;

    // True when the nibble is a legal decimal digit
    function automatic logic is_bcd(input logic [3:0] v);
        return (v <= BCD_MAX);
    endfunction

    // Decimal increment of one digit, 9 rolls over to 0
    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v >= BCD_MAX) begin
            r = BCD_ZERO;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Decimal decrement of one digit, 0 rolls under to 9
    function automatic logic [3:0] bcd_dec(input logic [3:0] v);
        logic [3:0] r;
        if (v == BCD_ZERO) begin
            r = BCD_MAX;
        end else if (v > BCD_MAX) begin
            r = BCD_MAX;
        end else begin
            r = v - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_ndigit_chk.sv
// -----------------------------------------------------------------------------
// bcd_counter_ndigit_chk
// Invariant checker bound into the counter: every digit of Q stays a legal
// decimal digit, and the wrap and load-error pulses never occur together
// (a load edge is never a wrap edge).
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (checks disabled while low)
//   q_i      counter value
//   wrap_i   registered wrap pulse
//   lderr_i  registered load-error pulse
// -----------------------------------------------------------------------------
module bcd_counter_ndigit_chk
    import bcd_counter_ndigit_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BCD_W*DIGITS-1:0] q_i,
    input  logic                    wrap_i,
    input  logic                    lderr_i
);

    // Reduces every nibble of a counter word to one legality flag
    function automatic logic all_bcd(input logic [BCD_W*DIGITS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & is_bcd(v[i*BCD_W +: BCD_W]);
        end
        return ok;
    endfunction

    digits_bcd_a: assert property (@(posedge clk_i) disable iff (!rst_ni) all_bcd(q_i));

    wrap_lderr_excl_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(wrap_i && lderr_i));

endmodule

// File: rtl/bcd_counter_ndigit_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_counter_ndigit_digit_cell
// One BCD digit register. The top decides per edge whether the digit holds,
// loads, increments or decrements; the cell applies that operation and reports
// whether it currently sits at 9 or 0 so the top can build carry/borrow chains.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset (digit -> 0)
//   op_i       operation for the next edge
//   d_i        load value for this digit
//   q_o        registered digit value
//   q_next_o   value the digit takes on the next edge
//   is_max_o   digit is 9
//   is_zero_o  digit is 0
//   ld_bad_o   a load is requested with a non-decimal nibble (loaded as 0)
// -----------------------------------------------------------------------------
module bcd_counter_ndigit_digit_cell
    import bcd_counter_ndigit_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  cell_op_e         op_i,
    input  logic [BCD_W-1:0] d_i,
    output logic [BCD_W-1:0] q_o,
    output logic [BCD_W-1:0] q_next_o,
    output logic             is_max_o,
    output logic             is_zero_o,
    output logic             ld_bad_o
);

    logic [BCD_W-1:0] q_d;
    logic [BCD_W-1:0] q_q;
    logic             ld_bad_s;

    // Next-state selection for the digit
    always_comb begin
        q_d      = q_q;
        ld_bad_s = 1'b0;
        case (op_i)
            CELL_LOAD: begin
                // Illegal nibbles are squashed to 0 so Q never leaves BCD range
                if (is_bcd(d_i)) begin
                    q_d = d_i;
                end else begin
                    q_d      = BCD_ZERO;
                    ld_bad_s = 1'b1;
                end
            end
            CELL_INC:  q_d = bcd_inc(q_q);
            CELL_DEC:  q_d = bcd_dec(q_q);
            CELL_HOLD: q_d = q_q;
            default:   q_d = q_q;
        endcase
    end

    // Digit register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o       = q_q;
    assign q_next_o  = q_d;
    assign is_max_o  = (q_q == BCD_MAX);
    assign is_zero_o = (q_q == BCD_ZERO);
    assign ld_bad_o  = ld_bad_s;

endmodule

// File: rtl/bcd_counter_ndigit.sv
// -----------------------------------------------------------------------------
// bcd_counter_ndigit
// Parametrised N-digit BCD up/down counter. Each digit is a separate cell; the
// top builds "all lower digits are 9" / "all lower digits are 0" prefix chains
// so every digit decides its increment/decrement on the same edge.
// Optional feature macro: BCD_CMP_EN adds cmp_val_i / match_o.
// Parameters:
//   DIGITS     number of BCD digits (1..8)
//   WRAP_MODE  1: wrap at the 0 / all-9s boundary, 0: saturate there
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low clear
//   enable_i   count enable (ignored while load_i=1)
//   load_i     synchronous parallel load of d_i
//   up_i       1 = increment, 0 = decrement
//   d_i        load value, digit 0 in d_i[3:0]
//   q_o        counter value, digit 0 in q_o[3:0]
//   co_o       combinational terminal count
//   wrap_o     registered 1-cycle pulse after a wrap edge
//   lderr_o    registered 1-cycle pulse after a load with a nibble > 9
//   cmp_val_i  (BCD_CMP_EN) compare value
//   match_o    (BCD_CMP_EN) registered pulse when Q newly equals cmp_val_i
// -----------------------------------------------------------------------------
module bcd_counter_ndigit
    import bcd_counter_ndigit_pkg::*;
#(
    parameter int          DIGITS    = 4,
    parameter int unsigned WRAP_MODE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic                    up_i,
    input  logic [BCD_W*DIGITS-1:0] d_i,
    output logic [BCD_W*DIGITS-1:0] q_o,
    output logic                    co_o,
    output logic                    wrap_o,
    output logic                    lderr_o
`ifdef BCD_CMP_EN
    ,
    input  logic [BCD_W*DIGITS-1:0] cmp_val_i,
    output logic                    match_o
`endif
);

    localparam int Q_W     = BCD_W * DIGITS;
    localparam bit WRAP_EN = (WRAP_MODE != 0);

    logic [Q_W-1:0]    q_s;
    logic [Q_W-1:0]    q_next_s;
    logic [DIGITS-1:0] is_max_s;
    logic [DIGITS-1:0] is_zero_s;
    logic [DIGITS-1:0] ld_bad_s;
    logic [DIGITS:0]   max_pre_s;
    logic [DIGITS:0]   zero_pre_s;
    cell_op_e          op_s [DIGITS];

    logic count_req_s;
    logic at_bound_s;
    logic count_s;
    logic co_s;
    logic wrap_d;
    logic wrap_q;
    logic lderr_d;
    logic lderr_q;

    // Prefix chains: bit i means every digit below i is 9 (or 0)
    always_comb begin
        max_pre_s     = '0;
        zero_pre_s    = '0;
        max_pre_s[0]  = 1'b1;
        zero_pre_s[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            max_pre_s[i+1]  = max_pre_s[i] & is_max_s[i];
            zero_pre_s[i+1] = zero_pre_s[i] & is_zero_s[i];
        end
    end

    // Terminal-count and count-permission decode; saturation blocks the edge at the boundary
    always_comb begin
        count_req_s = enable_i & ~load_i;
        if (up_i) begin
            at_bound_s = max_pre_s[DIGITS];
        end else begin
            at_bound_s = zero_pre_s[DIGITS];
        end
        co_s = count_req_s & at_bound_s;
        if (WRAP_EN) begin
            count_s = count_req_s;
            wrap_d  = co_s;
        end else begin
            count_s = count_req_s & ~at_bound_s;
            wrap_d  = 1'b0;
        end
        lderr_d = load_i & (|ld_bad_s);
    end

    // Per-digit operation: load beats count beats hold
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            op_s[i] = CELL_HOLD;
            if (load_i) begin
                op_s[i] = CELL_LOAD;
            end else if (count_s) begin
                if (up_i) begin
                    op_s[i] = max_pre_s[i] ? CELL_INC : CELL_HOLD;
                end else begin
                    op_s[i] = zero_pre_s[i] ? CELL_DEC : CELL_HOLD;
                end
            end else begin
                op_s[i] = CELL_HOLD;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_counter_ndigit_digit_cell u_cell (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .op_i      (op_s[g]),
            .d_i       (d_i[g*BCD_W +: BCD_W]),
            .q_o       (q_s[g*BCD_W +: BCD_W]),
            .q_next_o  (q_next_s[g*BCD_W +: BCD_W]),
            .is_max_o  (is_max_s[g]),
            .is_zero_o (is_zero_s[g]),
            .ld_bad_o  (ld_bad_s[g])
        );
    end

    // Event pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrap_q  <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            wrap_q  <= wrap_d;
            lderr_q <= lderr_d;
        end
    end

    assign q_o     = q_s;
    assign co_o    = co_s;
    assign wrap_o  = wrap_q;
    assign lderr_o = lderr_q;

`ifdef BCD_CMP_EN
    logic match_d;
    logic match_q;

    // Pulse only on the edge where Q arrives at the compare value, not while it stays there
    always_comb begin
        match_d = (q_next_s == cmp_val_i) && (q_s != cmp_val_i);
    end

    // Match pulse register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_o = match_q;
`else
    logic unused_next_s;
    assign unused_next_s = ^q_next_s;
`endif

    bcd_counter_ndigit_chk #(
        .DIGITS (DIGITS)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .q_i     (q_s),
        .wrap_i  (wrap_q),
        .lderr_i (lderr_q)
    );

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_ndigit
// Directed bench for the 4-digit BCD counter. Two instances share the stimulus:
// dut_w wraps at the boundary, dut_s saturates. Expected values are written out
// by hand next to each step.
// -----------------------------------------------------------------------------
module tb_bcd_counter_ndigit;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic        up;
    logic [15:0] d;
    logic [15:0] q_w, q_s;
    logic        co_w, co_s;
    logic        wrap_w, wrap_s;
    logic        lderr_w, lderr_s;
`ifdef BCD_CMP_EN
    logic [15:0] cmp_val;
    logic        match_w, match_s;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bcd_counter_ndigit #(.DIGITS(4), .WRAP_MODE(1)) dut_w (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .load_i   (load),
        .up_i     (up),
        .d_i      (d),
        .q_o      (q_w),
        .co_o     (co_w),
        .wrap_o   (wrap_w),
        .lderr_o  (lderr_w)
`ifdef BCD_CMP_EN
        ,
        .cmp_val_i (cmp_val),
        .match_o   (match_w)
`endif
    );

    bcd_counter_ndigit #(.DIGITS(4), .WRAP_MODE(0)) dut_s (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .load_i   (load),
        .up_i     (up),
        .d_i      (d),
        .q_o      (q_s),
        .co_o     (co_s),
        .wrap_o   (wrap_s),
        .lderr_o  (lderr_s)
`ifdef BCD_CMP_EN
        ,
        .cmp_val_i (cmp_val),
        .match_o   (match_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        up     = 1'b1;
        d      = 16'h0000;
`ifdef BCD_CMP_EN
        cmp_val = 16'h0005;
`endif
        #2;
        check_eq("rst_q",     32'(q_w), 32'h0000);
        check_eq("rst_wrap",  32'(wrap_w), 32'h0);
        check_eq("rst_lderr", 32'(lderr_w), 32'h0);
        check_eq("rst_co",    32'(co_w), 32'h0);
`ifdef BCD_CMP_EN
        check_eq("rst_match", 32'(match_w), 32'h0);
`endif
        #1;
        rst_n = 1'b1;

        // 1: count to 1234, then clear asynchronously between edges
        load = 1'b1; d = 16'h1231;
        tick();
        check_eq("t1_load", 32'(q_w), 32'h1231);
        load = 1'b0; enable = 1'b1; up = 1'b1;
        tick(); tick(); tick();
        check_eq("t1_count", 32'(q_w), 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_clr_q",     32'(q_w), 32'h0000);
        check_eq("t1_clr_wrap",  32'(wrap_w), 32'h0);
        check_eq("t1_clr_lderr", 32'(lderr_w), 32'h0);
        #1;
        rst_n = 1'b1;
        enable = 1'b0;

        // 2: load 0999 with enable high (load wins), then carry through three digits
        load = 1'b1; enable = 1'b1; up = 1'b1; d = 16'h0999;
        tick();
        check_eq("t2_load", 32'(q_w), 32'h0999);
        load = 1'b0;
        #1;
        check_eq("t2_co_off", 32'(co_w), 32'h0);
        tick();
        check_eq("t2_carry", 32'(q_w), 32'h1000);
        check_eq("t2_wrap",  32'(wrap_w), 32'h0);

        // 3: wrap up from 9999 and back down from 0000
        load = 1'b1; d = 16'h9999;
        tick();
        load = 1'b0; enable = 1'b1; up = 1'b1;
        #1;
        check_eq("t3_co_up_w", 32'(co_w), 32'h1);
        check_eq("t3_co_up_s", 32'(co_s), 32'h1);
        tick();
        check_eq("t3_q_up_w",    32'(q_w), 32'h0000);
        check_eq("t3_wrap_up_w", 32'(wrap_w), 32'h1);
        check_eq("t3_q_up_s",    32'(q_s), 32'h9999);
        check_eq("t3_wrap_up_s", 32'(wrap_s), 32'h0);
        up = 1'b0;
        #1;
        check_eq("t3_co_dn_w", 32'(co_w), 32'h1);
        tick();
        check_eq("t3_q_dn_w",    32'(q_w), 32'h9999);
        check_eq("t3_wrap_dn_w", 32'(wrap_w), 32'h1);
        check_eq("t3_q_dn_s",    32'(q_s), 32'h9998);
        enable = 1'b0;
        tick();
        check_eq("t3_wrap_drop", 32'(wrap_w), 32'h0);
        check_eq("t3_hold",      32'(q_w), 32'h9999);

        // 4: saturating instance holds at 0000 counting down
        load = 1'b1; d = 16'h0000;
        tick();
        load = 1'b0; enable = 1'b1; up = 1'b0;
        tick(); tick(); tick();
        check_eq("t4_q_s",    32'(q_s), 32'h0000);
        check_eq("t4_co_s",   32'(co_s), 32'h1);
        check_eq("t4_wrap_s", 32'(wrap_s), 32'h0);
        check_eq("t4_q_w",    32'(q_w), 32'h9997);

        // 5: illegal nibbles load as 0; load beats enable
        load = 1'b1; enable = 1'b0; d = 16'h3A7F;
        tick();
        check_eq("t5_q_bad",  32'(q_w), 32'h3070);
        check_eq("t5_lderr",  32'(lderr_w), 32'h1);
        load = 1'b0;
        tick();
        check_eq("t5_lderr_drop", 32'(lderr_w), 32'h0);
        check_eq("t5_hold",       32'(q_w), 32'h3070);
        load = 1'b1; enable = 1'b1; up = 1'b1; d = 16'h0042;
        tick();
        check_eq("t5_load_wins", 32'(q_w), 32'h0042);
        d = 16'h9999;
        tick();
        #1;
        check_eq("t5_co_load", 32'(co_w), 32'h0);

        // Direction flips every edge, including a borrow across digits
        load = 1'b1; enable = 1'b0; d = 16'h0500;
        tick();
        load = 1'b0; enable = 1'b1; up = 1'b1;
        tick();
        check_eq("dir_up", 32'(q_w), 32'h0501);
        up = 1'b0;
        tick();
        check_eq("dir_dn", 32'(q_w), 32'h0500);
        tick();
        check_eq("dir_borrow", 32'(q_w), 32'h0499);
        enable = 1'b0;

`ifdef BCD_CMP_EN
        // 6: match pulses only on arrival at 0005
        cmp_val = 16'h0005;
        load = 1'b1; d = 16'h0003;
        tick();
        check_eq("t6_m3", 32'(match_w), 32'h0);
        load = 1'b0; enable = 1'b1; up = 1'b1;
        tick();
        check_eq("t6_m4", 32'(match_w), 32'h0);
        tick();
        check_eq("t6_q5", 32'(q_w), 32'h0005);
        check_eq("t6_m5", 32'(match_w), 32'h1);
        tick();
        check_eq("t6_m6", 32'(match_w), 32'h0);
        tick();
        check_eq("t6_m7", 32'(match_w), 32'h0);
        enable = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
